// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-snapshotted 4-digit multiplexed 7-segment driver with PWM dimming
module seg7_scan_driver #(
    parameter int unsigned SUBSLOT_CYCLES = 6250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    input  logic [2:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);
    localparam int PW = (SUBSLOT_CYCLES > 1) ? $clog2(SUBSLOT_CYCLES) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    sub_q, sub_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   dig_q;
    logic [3:0]    dpm_q;
    logic          lz_q;
    logic          pt, sub_wrap, frame_wrap, active;
    logic [3:0]    cur;
    logic [3:0]    blk;
    logic [6:0]    glyph;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    assign pt         = pre_q == PW'(SUBSLOT_CYCLES - 1);
    assign sub_wrap   = pt && sub_q == 3'd7;
    assign frame_wrap = sub_wrap && idx_q == 2'd3;
    assign active     = sub_q <= brightness;
    assign cur        = dig_q[idx_q*4 +: 4];

    // scan counters: prescaler -> PWM sub-slot -> digit index
    always_comb begin
        pre_d = pt ? '0 : pre_q + 1'b1;
        sub_d = pt ? sub_q + 3'd1 : sub_q;
        idx_d = sub_wrap ? idx_q + 2'd1 : idx_q;
    end

    // leading-zero mask: digit k blanks only when it and every higher digit is zero
    always_comb begin
        blk[3] = lz_q && dig_q[15:12] == 4'd0;
        blk[2] = blk[3] && dig_q[11:8] == 4'd0;
        blk[1] = blk[2] && dig_q[7:4] == 4'd0;
        blk[0] = 1'b0;
    end

    // BCD glyph decode; 10-14 show a dash, 15 is the upstream blank code
    always_comb begin
        glyph = 7'h3F;
        case (cur)
            4'd0: glyph = 7'h40;
            4'd1: glyph = 7'h79;
            4'd2: glyph = 7'h24;
            4'd3: glyph = 7'h30;
            4'd4: glyph = 7'h19;
            4'd5: glyph = 7'h12;
            4'd6: glyph = 7'h02;
            4'd7: glyph = 7'h78;
            4'd8: glyph = 7'h00;
            4'd9: glyph = 7'h10;
            4'd15: glyph = 7'h7F;
            default: glyph = 7'h3F;
        endcase
    end

    // pin values; blanked digits still assert their anode so PWM timing stays uniform
    always_comb begin
        an_d  = active ? ~(4'b0001 << idx_q) : 4'hF;
        seg_d = (active && !blk[idx_q]) ? glyph : 7'h7F;
        dp_d  = active ? ~dpm_q[idx_q] : 1'b1;
    end

    // counter and registered-output state
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            sub_q       <= '0;
            idx_q       <= '0;
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= frame_wrap;
        end
    end

    // snapshot follows the inputs during reset and reloads only at frame boundaries
    always_ff @(posedge clk) begin
        if (reset || frame_wrap) begin
            dig_q <= digits_in;
            dpm_q <= dp_in;
            lz_q  <= lz_blank;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, snapshotting, PWM, blanking and reset
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic        lz_blank = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    int          compared = 0;
    int          mismatched = 0;

    seg7_scan_driver #(.SUBSLOT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .lz_blank(lz_blank), .brightness(brightness),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [15:0] d, input logic [3:0] p, input logic lz, input logic [2:0] b);
        @(negedge clk);
        digits_in = d;
        dp_in = p;
        lz_blank = lz;
        brightness = b;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                mismatched++;
                $display("FAIL reset an/seg/dp/fs=%b/%h/%b/%b want 1111/7f/1/0", an, seg, dp, frame_start);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        logic [6:0] g [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        do_reset(16'h1234, 4'h0, 1'b0, 3'd7);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            compared++;
            if ({an, seg, dp, frame_start} !== {~(4'b0001 << ((c-1)/16)), g[(c-1)/16], 1'b1, c == 64}) begin
                mismatched++;
                $display("FAIL scan c=%0d an/seg/dp/fs=%b/%h/%b/%b want %b/%h/1/%b",
                         c, an, seg, dp, frame_start, ~(4'b0001 << ((c-1)/16)), g[(c-1)/16], c == 64);
            end
        end
    endtask

    task automatic test_no_tearing();
        logic [6:0] g [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h00, 7'h78, 7'h02, 7'h12};
        do_reset(16'h1234, 4'h0, 1'b0, 3'd7);
        for (int c = 1; c <= 128; c++) begin
            @(negedge clk);
            compared++;
            if ({an, seg, frame_start} !== {~(4'b0001 << (((c-1)/16) % 4)), g[(c-1)/16], (c == 64) || (c == 128)}) begin
                mismatched++;
                $display("FAIL tearing c=%0d an/seg/fs=%b/%h/%b want %b/%h/%b",
                         c, an, seg, frame_start, ~(4'b0001 << (((c-1)/16) % 4)), g[(c-1)/16], (c == 64) || (c == 128));
            end
            if (c == 20) digits_in = 16'h5678;
        end
    endtask

    task automatic test_brightness(input logic [2:0] b, input int on_cycles);
        int cnt;
        logic [6:0] g [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        do_reset(16'h1234, 4'h0, 1'b0, b);
        for (int s = 0; s < 4; s++) begin
            cnt = 0;
            for (int p = 0; p < 16; p++) begin
                @(negedge clk);
                if (an !== 4'hF) cnt++;
                compared++;
                if ({an, seg} !== ((p < on_cycles) ? {~(4'b0001 << s), g[s]} : {4'hF, 7'h7F})) begin
                    mismatched++;
                    $display("FAIL pwm b=%0d slot=%0d p=%0d an/seg=%b/%h", b, s, p, an, seg);
                end
            end
            compared++;
            if (cnt !== on_cycles) begin
                mismatched++;
                $display("FAIL pwm_count b=%0d slot=%0d got %0d want %0d", b, s, cnt, on_cycles);
            end
        end
    endtask

    task automatic test_slots(input string name, input logic [15:0] d, input logic [3:0] p,
                              input logic lz, input logic [27:0] gpack);
        logic [6:0] g [4];
        logic [27:0] gp;
        gp = gpack;
        for (int s = 0; s < 4; s++) g[s] = gp[s*7 +: 7];
        do_reset(d, p, lz, 3'd7);
        for (int s = 0; s < 4; s++) begin
            for (int q = 0; q < 16; q++) begin
                @(negedge clk);
                if (q == 5) begin
                    compared++;
                    if ({an, seg, dp} !== {~(4'b0001 << s), g[s], ~p[s]}) begin
                        mismatched++;
                        $display("FAIL %s slot=%0d an/seg/dp=%b/%h/%b want %b/%h/%b",
                                 name, s, an, seg, dp, ~(4'b0001 << s), g[s], ~p[s]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        do_reset(16'h1234, 4'h0, 1'b0, 3'd7);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        digits_in = 16'h9876;
        @(negedge clk);
        reset = 1'b0;
        digits_in = 16'h1111;
        compared++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL midreset an/seg/dp/fs=%b/%h/%b/%b want 1111/7f/1/0", an, seg, dp, frame_start);
        end
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            compared++;
            if (frame_start !== (c == 64)) begin
                mismatched++;
                $display("FAIL midreset_fs c=%0d got %b want %b", c, frame_start, c == 64);
            end
            if (c == 1 || c == 16 || c == 17) begin
                compared++;
                if ({an, seg} !== ((c < 17) ? {4'b1110, 7'h02} : {4'b1101, 7'h78})) begin
                    mismatched++;
                    $display("FAIL midreset_digit c=%0d an/seg=%b/%h", c, an, seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_brightness(3'd1, 4);
        test_brightness(3'd0, 2);
        test_slots("lz0050", 16'h0050, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40});
        test_slots("lz0000", 16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        test_slots("nolz0050", 16'h0050, 4'b0101, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40});
        test_slots("f0af", 16'hF0AF, 4'b0000, 1'b1, {7'h7F, 7'h40, 7'h3F, 7'h7F});
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the timer's 16-bit four-digit BCD output bus.
- Snapshots the bus once per refresh frame and time-multiplexes the four digits onto a common-anode 7-segment module with active-low anodes and segments.
- Adds per-digit decimal points, leading-zero blanking and 8-level PWM brightness.
- Sits between the timer top level and the board pins.

Parameters:
- SUBSLOT_CYCLES, 6250, clk cycles per PWM sub-slot. 8 sub-slots make one digit slot; 4 slots make one frame. At 50 MHz this gives 1 kHz per digit. Benches use 2. Legal range is 1 or more.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- digits_in  in  16  4 BCD digits; [3:0] is digit 0 (rightmost, an[0]), [15:12] is digit 3
- dp_in  in  4  decimal point per digit, 1 = lit
- lz_blank  in  1  1 = suppress leading zeros
- brightness  in  3  duty select, 0 = 1/8, 7 = 8/8
- an  out  4  anode enables, active low
- seg  out  7  {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low
- frame_start  out  1  1-cycle pulse when a new snapshot is taken

Behaviour:
- Reset, synchronous, takes priority over everything.
  - Outputs: an=4'hF, seg=7'h7F, dp=1, frame_start=0.
  - Internal: prescaler=0, subslot=0, idx=0.
  - The snapshot registers load digits_in, dp_in and lz_blank live every reset cycle.
- Prescaler counts 0..SUBSLOT_CYCLES-1. On reaching terminal count it returns to 0 and subslot increments (mod 8).
- When subslot wraps 7->0, idx increments (mod 4).
- When idx wraps 3->0 (same cycle as the subslot and prescaler wrap):
  - Snapshot reloads from digits_in, dp_in and lz_blank.
  - frame_start pulses for that one cycle.
  - The inputs are sampled in that cycle. Input changes mid-frame are never visible, so there is no tearing.
- brightness is not snapshotted. It is sampled live each cycle.
- Outputs are registered: one clk of latency from internal state (idx, subslot, snapshot) to pins.
  - Active: an[idx]=0 and all other an bits = 1, while subslot <= brightness.
  - Otherwise: an=4'hF, seg=7'h7F, dp=1.
- Glyph decode of the current snapshot digit d:
  - 0-9: standard glyphs. 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 10-14: dash, seg=7'h3F.
  - 15: blank, seg=7'h7F. This is the upstream flicker-off code.
- Leading-zero blanking (snapshot lz_blank=1):
  - Digit k>0 is forced to seg=7'h7F when its value and all higher digits are 0.
  - Digit 0 is never blanked, so 0000 shows "0".
  - dp is not affected by blanking; dp = ~dp_snapshot[idx] whenever the anode is active.
- Blanked digits keep their anode-active timing (an still asserts), so PWM timing is uniform.
- Frame length = 32*SUBSLOT_CYCLES cycles, exactly, with no gaps.
- Reset mid-frame aborts immediately. Scanning restarts at idx 0, subslot 0 on the first cycle after reset deasserts.
  - First frame_start occurs 32*SUBSLOT_CYCLES cycles after deassert.
  - The first frame displays the value present during the last reset cycle.

Test Plan:
1. SUBSLOT_CYCLES=2, brightness=7, digits_in=16'h1234, lz_blank=0 -> after reset, cycles 1-16 an=4'b1110 seg=7'h19 ('4'); cycles 17-32 an=4'b1101 seg=7'h30; cycles 33-48 an=4'b1011 seg=7'h24; cycles 49-64 an=4'b0111 seg=7'h79; frame_start high at cycle 64 only.
2. Change digits_in 16'h1234->16'h5678 at cycle 20 -> digits 1-3 of the current frame still show 3,2,1; the next frame shows 8,7,6,5.
3. brightness=1 -> per 16-cycle slot, an active for exactly 4 cycles (subslots 0-1) and 4'hF for 12; brightness=0 -> 2 of 16.
4. lz_blank=1, digits_in=16'h0050 -> digits 3 and 2 seg=7'h7F, digit 1 shows '5', digit 0 shows '0'; digits_in=16'h0000 -> only digit 0 shows '0'; dp_in=4'b1000 -> dp=0 during digit 3 slot despite blanking.
5. digits_in=16'hF0AF -> digits 0 and 3 blank, digit 1 dash 7'h3F, digit 2 '0'.
6. Assert reset for 1 cycle during the digit 2 slot -> next cycle an=4'hF seg=7'h7F dp=1; then digit 0 is displayed with the value captured during reset.
